// File: rtl/bin_to_bcd_pkg.sv
// Package for the 4-bit binary to two-digit BCD converter.
// It holds the BCD digit type, the digit limits and the layout of the registered output word.
package bin_to_bcd_pkg;

  localparam int BCD_W     = 4;
  localparam int MAX_DIGIT = 9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Registered output word: tens digit, ones digit, range flag (9 bits).
  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
    logic       valid;
  } bcd_out_t;

  // Double-dabble correction: a digit of 5 or more gets 3 added before the shift.
  function automatic bcd_digit_t dabble_adjust(input bcd_digit_t digit);
    bcd_digit_t adj;
    adj = digit;
    if (digit >= bcd_digit_t'(5)) begin
      adj = digit + bcd_digit_t'(3);
    end
    return adj;
  endfunction

endpackage

// File: rtl/bin_to_bcd_core.sv
// Combinational core of bin_to_bcd.
// It splits the IN_W-bit input into tens and ones digits using shift-add-3 (double-dabble),
// and it raises in_range when the input is no greater than MAX_VAL.
// Anything above two digits is truncated.
module bin_to_bcd_core
  import bin_to_bcd_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int MAX_VAL = MAX_DIGIT
) (
  input  logic [IN_W-1:0] bin,
  output bcd_digit_t      tens,
  output bcd_digit_t      ones,
  output logic            in_range
);

  // Scratch register layout: {tens, ones, remaining binary bits}.
  localparam int SR_W = 2*BCD_W + IN_W;
  localparam logic [IN_W-1:0] MAX_BIN = IN_W'(MAX_VAL);

  logic [SR_W-1:0] stage [0:IN_W];
  logic [IN_W-1:0] unused_low_bits;

  assign stage[0] = {{(2*BCD_W){1'b0}}, bin};

  // One adjust-then-shift step per input bit, unrolled into IN_W combinational stages.
  genvar gi;
  generate
    for (gi = 0; gi < IN_W; gi++) begin : g_dabble
      bcd_digit_t      tens_adj;
      bcd_digit_t      ones_adj;
      logic [SR_W-1:0] adjusted;

      assign tens_adj = dabble_adjust(stage[gi][IN_W+BCD_W +: BCD_W]);
      assign ones_adj = dabble_adjust(stage[gi][IN_W +: BCD_W]);
      assign adjusted = {tens_adj, ones_adj, stage[gi][IN_W-1:0]};
      assign stage[gi+1] = adjusted << 1;
    end
  endgenerate

  assign tens            = stage[IN_W][IN_W+BCD_W +: BCD_W];
  assign ones            = stage[IN_W][IN_W +: BCD_W];
  // After IN_W shifts, the binary field holds only shifted-in zeros.
  assign unused_low_bits = stage[IN_W][IN_W-1:0];

  // The range check is an unsigned compare against the largest accepted value.
  assign in_range = (bin <= MAX_BIN);

endmodule

// File: rtl/bin_to_bcd.sv
// bin_to_bcd: registered 4-bit binary to two-digit BCD converter with range check.
// Latency is one clock and a new conversion can start every cycle.
// rst is asynchronous and active-high, and it clears all outputs immediately.
// Build option BIN2BCD_FULL_RANGE_EN:
//   - when defined, inputs above MAX_VAL are still converted (tens=1, ones=bin-10), with valid=0;
//   - when undefined, those inputs produce all-zero digits with valid=0.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int MAX_VAL = MAX_DIGIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] bin,
  output bcd_digit_t      tens,
  output bcd_digit_t      ones,
  output logic            valid
);

  bcd_digit_t core_tens;
  bcd_digit_t core_ones;
  logic       core_in_range;

  bcd_out_t   out_reg;
  bcd_out_t   out_next;

  bin_to_bcd_core #(
    .IN_W    (IN_W),
    .MAX_VAL (MAX_VAL)
  ) u_core (
    .bin      (bin),
    .tens     (core_tens),
    .ones     (core_ones),
    .in_range (core_in_range)
  );

  // Apply the out-of-range policy to the converted digits before they are registered.
  always_comb begin
    out_next       = '0;
    out_next.valid = core_in_range;
`ifdef BIN2BCD_FULL_RANGE_EN
    out_next.tens  = core_tens;
    out_next.ones  = core_ones;
`else
    out_next.tens  = core_in_range ? core_tens : '0;
    out_next.ones  = core_in_range ? core_ones : '0;
`endif
  end

  // Output register: cleared asynchronously by rst, otherwise loaded on every clk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg <= '0;
    end else begin
      out_reg <= out_next;
    end
  end

  assign tens  = out_reg.tens;
  assign ones  = out_reg.ones;
  assign valid = out_reg.valid;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed testbench for bin_to_bcd.
// Covers reset, the in-range sweep, the out-of-range sweep, back-to-back boundaries
// and an asynchronous reset applied mid-stream.
// It honours BIN2BCD_FULL_RANGE_EN when that macro is defined for the build.
module tb_bin_to_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] bin = 4'd0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       valid;

  int check_count = 0;
  int pass_count  = 0;

  bin_to_bcd dut (
    .clk   (clk),
    .rst   (rst),
    .bin   (bin),
    .tens  (tens),
    .ones  (ones),
    .valid (valid)
  );

  always #5 clk = ~clk;

  // Hand-derived expected output for one input value, returned as {tens, ones, valid}.
  function automatic logic [8:0] expect_of(input int b);
    if (b <= 9) return {4'd0, 4'(b), 1'b1};
`ifdef BIN2BCD_FULL_RANGE_EN
    return {4'd1, 4'(b - 10), 1'b0};
`else
    return {4'd0, 4'd0, 1'b0};
`endif
  endfunction

  task automatic check_out(input string tag, input logic [8:0] got, input logic [8:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
      $display("ok   %-12s tens=%0d ones=%0d valid=%0d", tag, got[8:5], got[4:1], got[0]);
    end else begin
      $display("FAIL %-12s got tens=%0d ones=%0d valid=%0d, need tens=%0d ones=%0d valid=%0d",
               tag, got[8:5], got[4:1], got[0], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  // Drive a value at the falling edge, then check the registered result just after the next rising edge.
  task automatic convert(input string tag, input int b);
    @(negedge clk);
    bin = 4'(b);
    @(posedge clk);
    #1;
    check_out($sformatf("%s%0d", tag, b), {tens, ones, valid}, expect_of(b));
  endtask

  initial begin
    // 1: the reset value is visible immediately, and the first edge after release converts 7.
    bin = 4'd7;
    #2 rst = 1'b1;
    #1 check_out("rst_async", {tens, ones, valid}, 9'd0);
    @(posedge clk);
    #1 check_out("rst_hold", {tens, ones, valid}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_out("rst_rel", {tens, ones, valid}, 9'd0);
    @(posedge clk);
    #1 check_out("first7", {tens, ones, valid}, {4'd0, 4'd7, 1'b1});

    // 2: in-range sweep.
    for (int b = 0; b <= 9; b++) convert("in_", b);

    // 3: out-of-range sweep.
    for (int b = 10; b <= 15; b++) convert("out_", b);

    // 4: back-to-back boundaries. The output must hold the previous result until the edge.
    convert("b2b_", 9);
    @(negedge clk);
    bin = 4'd10;
    #1 check_out("hold9", {tens, ones, valid}, {4'd0, 4'd9, 1'b1});
    @(posedge clk);
    #1 check_out("b2b_10", {tens, ones, valid}, expect_of(10));
    convert("b2b_", 0);

    // 5: asynchronous reset between edges, then conversion resumes with one-cycle latency.
    convert("pre_", 5);
    #2 rst = 1'b1;
    #1 check_out("mid_rst", {tens, ones, valid}, 9'd0);
    @(posedge clk);
    #1 check_out("mid_hold", {tens, ones, valid}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    bin = 4'd3;
    @(posedge clk);
    #1 check_out("resume3", {tens, ones, valid}, {4'd0, 4'd3, 1'b1});
    convert("post_", 12);
    convert("post_", 8);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
